// File: rtl/serial_mag_comp.sv
// Bit-serial magnitude comparator: consumes W (a_bit, b_bit) pairs after a start
// pulse and reports a registered eq/gr/le result framed by a one-cycle done pulse.
module serial_mag_comp #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     bit_valid,
  input  logic                     a_bit,
  input  logic                     b_bit,
  output logic                     busy,
  output logic                     done,
  output logic                     eq,
  output logic                     gr,
  output logic                     le,
  output logic [$clog2(W+1)-1:0]   cnt
);

  localparam int             CW   = $clog2(W + 1);
  localparam logic [CW-1:0]  LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_GR = 2'd1,
    REL_LE = 2'd2
  } rel_t;

  state_t         state, state_nxt;
  rel_t           rel, rel_nxt, rel_upd;
  logic [CW-1:0]  cnt_nxt;
  logic           eq_nxt, gr_nxt, le_nxt;

  // Relation after folding in the current pair. LSB-first: every differing bit is
  // more significant than the ones before it, so it overrides. MSB-first: only the
  // first differing bit matters, so rel is frozen once it leaves EQ.
  always_comb begin
    rel_upd = rel;
    if (a_bit != b_bit) begin
      if (!MSB_FIRST || rel == REL_EQ) begin
        rel_upd = a_bit ? REL_GR : REL_LE;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path through the
  // case can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    rel_nxt   = rel;
    cnt_nxt   = cnt;
    eq_nxt    = eq;
    gr_nxt    = gr;
    le_nxt    = le;
    busy      = 1'b0;
    done      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          rel_nxt   = REL_EQ;
          cnt_nxt   = '0;
          eq_nxt    = 1'b0;
          gr_nxt    = 1'b0;
          le_nxt    = 1'b0;
        end
      end

      RUN: begin
        busy = 1'b1;
        if (start) begin
          // Abort and restart; the pair presented with start is not consumed.
          rel_nxt = REL_EQ;
          cnt_nxt = '0;
          eq_nxt  = 1'b0;
          gr_nxt  = 1'b0;
          le_nxt  = 1'b0;
        end else if (bit_valid) begin
          rel_nxt = rel_upd;
          cnt_nxt = cnt + CW'(1);
          if (cnt == LAST) begin
            // Result registers load with the final relation so they are valid
            // in the same cycle done is raised.
            state_nxt = DONE;
            eq_nxt    = (rel_upd == REL_EQ);
            gr_nxt    = (rel_upd == REL_GR);
            le_nxt    = (rel_upd == REL_LE);
          end
        end
      end

      DONE: begin
        done = 1'b1;
        if (start) begin
          state_nxt = RUN;
          rel_nxt   = REL_EQ;
          cnt_nxt   = '0;
          eq_nxt    = 1'b0;
          gr_nxt    = 1'b0;
          le_nxt    = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rel   <= REL_EQ;
      cnt   <= '0;
      eq    <= 1'b0;
      gr    <= 1'b0;
      le    <= 1'b0;
    end else begin
      state <= state_nxt;
      rel   <= rel_nxt;
      cnt   <= cnt_nxt;
      eq    <= eq_nxt;
      gr    <= gr_nxt;
      le    <= le_nxt;
    end
  end

  // Structural invariants of the result and counter.
  a_result_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({eq, gr, le}));
  a_done_onehot    : assert property (@(posedge clk) disable iff (!rst_n)
    done |-> $onehot({eq, gr, le}));
  a_cnt_bound      : assert property (@(posedge clk) disable iff (!rst_n)
    cnt <= CW'(W));

endmodule

// File: tb/tb_serial_mag_comp.sv
// Self-checking bench for serial_mag_comp: an LSB-first and an MSB-first instance
// compare the same operand pairs and both are checked against integer comparison.
module tb_serial_mag_comp;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic bit_valid = 1'b0;
  logic a_bit_l = 1'b0, b_bit_l = 1'b0;
  logic a_bit_m = 1'b0, b_bit_m = 1'b0;

  logic busy_l, done_l, eq_l, gr_l, le_l;
  logic busy_m, done_m, eq_m, gr_m, le_m;
  logic [CW-1:0] cnt_l, cnt_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_mag_comp #(.W(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
    .a_bit(a_bit_l), .b_bit(b_bit_l),
    .busy(busy_l), .done(done_l), .eq(eq_l), .gr(gr_l), .le(le_l), .cnt(cnt_l)
  );

  serial_mag_comp #(.W(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
    .a_bit(a_bit_m), .b_bit(b_bit_m),
    .busy(busy_m), .done(done_m), .eq(eq_m), .gr(gr_m), .le(le_m), .cnt(cnt_m)
  );

  // Observed status packed as {busy, done, eq, gr, le, cnt}.
  wire [CW+4:0] obs_l = {busy_l, done_l, eq_l, gr_l, le_l, cnt_l};
  wire [CW+4:0] obs_m = {busy_m, done_m, eq_m, gr_m, le_m, cnt_m};

  // Reference: plain integer comparison, returned as {eq, gr, le}.
  function automatic logic [2:0] ref_rel(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a == b)     return 3'b100;
    else if (a > b) return 3'b010;
    else            return 3'b001;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_noise();
    a_bit_l = 1'($urandom_range(0, 1));
    b_bit_l = 1'($urandom_range(0, 1));
    a_bit_m = 1'($urandom_range(0, 1));
    b_bit_m = 1'($urandom_range(0, 1));
  endtask

  // One framed comparison of a vs b with a given number of stall cycles. With
  // started=1 the start pulse was already issued by the caller. With chain=1 a new
  // start is raised during the done cycle and the task returns in the next RUN.
  task automatic drive_compare(input string name, input logic [W-1:0] a,
                               input logic [W-1:0] b, input int stalls,
                               input bit chain, input bit started);
    logic [2:0]    exp_rel;
    logic [CW+4:0] exp;
    int            consumed;
    int            stalls_left;
    bit            stall;
    exp_rel = ref_rel(a, b);
    if (!started) begin
      start = 1'b1;
      bit_valid = 1'b1;
      drive_noise();
      step();
      start = 1'b0;
    end
    consumed = 0;
    stalls_left = stalls;
    while (consumed < W) begin
      exp = {1'b1, 1'b0, 3'b000, CW'(consumed)};
      checks++;
      if (obs_l !== exp || obs_m !== exp) begin
        errors++;
        $display("FAIL %s run pair=%0d lsb=%b msb=%b required=%b",
                 name, consumed, obs_l, obs_m, exp);
      end
      stall = (stalls_left > 0) && ($urandom_range(0, 1) == 1 || consumed == W - 1);
      if (stall) begin
        bit_valid = 1'b0;
        drive_noise();
        stalls_left--;
      end else begin
        bit_valid = 1'b1;
        a_bit_l = a[consumed];
        b_bit_l = b[consumed];
        a_bit_m = a[W-1-consumed];
        b_bit_m = b[W-1-consumed];
        consumed++;
      end
      step();
    end
    exp = {1'b0, 1'b1, exp_rel, CW'(W)};
    checks++;
    if (obs_l !== exp || obs_m !== exp) begin
      errors++;
      $display("FAIL %s done lsb=%b msb=%b required=%b", name, obs_l, obs_m, exp);
    end
    bit_valid = 1'b1;
    drive_noise();
    if (chain) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end else begin
      step();
      bit_valid = 1'b0;
      exp = {1'b0, 1'b0, exp_rel, CW'(W)};
      checks++;
      if (obs_l !== exp || obs_m !== exp) begin
        errors++;
        $display("FAIL %s hold lsb=%b msb=%b required=%b", name, obs_l, obs_m, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (obs_l !== '0 || obs_m !== '0) begin
      errors++;
      $display("FAIL reset_initial lsb=%b msb=%b required=0", obs_l, obs_m);
    end
    start = 1'b1;
    bit_valid = 1'b1;
    step();
    step();
    checks++;
    if (obs_l !== '0 || obs_m !== '0) begin
      errors++;
      $display("FAIL reset_held lsb=%b msb=%b required=0", obs_l, obs_m);
    end
    start = 1'b0;
    bit_valid = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    drive_compare("eq_a5", 8'hA5, 8'hA5, 0, 1'b0, 1'b0);
    drive_compare("gr_81_7f", 8'h81, 8'h7F, 0, 1'b0, 1'b0);
    drive_compare("le_01_02", 8'h01, 8'h02, 0, 1'b0, 1'b0);
    drive_compare("gr_40_3f", 8'h40, 8'h3F, 0, 1'b0, 1'b0);
    drive_compare("min_max", 8'h00, 8'hFF, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    drive_compare("stall_81_7f", 8'h81, 8'h7F, 3, 1'b0, 1'b0);
    drive_compare("stall_40_3f", 8'h40, 8'h3F, 3, 1'b0, 1'b0);
    drive_compare("stall_eq", 8'h5A, 8'h5A, 3, 1'b0, 1'b0);
  endtask

  task automatic test_idle_ignore();
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      drive_noise();
      step();
      checks++;
      if (obs_l !== {1'b0, 1'b0, 3'b100, CW'(W)} || obs_m !== {1'b0, 1'b0, 3'b100, CW'(W)}) begin
        errors++;
        $display("FAIL idle_ignore cyc=%0d lsb=%b msb=%b required=%b",
                 i, obs_l, obs_m, {1'b0, 1'b0, 3'b100, CW'(W)});
      end
    end
    bit_valid = 1'b0;
  endtask

  task automatic test_abort();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      drive_noise();
      step();
    end
    checks++;
    if (cnt_l !== CW'(4) || cnt_m !== CW'(4)) begin
      errors++;
      $display("FAIL abort_precount lsb=%0d msb=%0d required=4", cnt_l, cnt_m);
    end
    start = 1'b1;
    bit_valid = 1'b1;
    drive_noise();
    step();
    start = 1'b0;
    drive_compare("abort_10_20", 8'h10, 8'h20, 0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      drive_noise();
      step();
    end
    bit_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_l !== '0 || obs_m !== '0) begin
      errors++;
      $display("FAIL async_reset lsb=%b msb=%b required=0", obs_l, obs_m);
    end
    step();
    checks++;
    if (obs_l !== '0 || obs_m !== '0) begin
      errors++;
      $display("FAIL async_reset_hold lsb=%b msb=%b required=0", obs_l, obs_m);
    end
    rst_n = 1'b1;
    drive_compare("post_reset_ff_00", 8'hFF, 8'h00, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    drive_compare("b2b_first", 8'h33, 8'h44, 1, 1'b1, 1'b0);
    drive_compare("b2b_second", 8'hC0, 8'h0C, 0, 1'b1, 1'b1);
    drive_compare("b2b_third", 8'h77, 8'h77, 2, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    bit           started;
    bit           chain;
    started = 1'b0;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      chain = (i != 29) && ($urandom_range(0, 2) == 0);
      drive_compare("random", a, b, $urandom_range(0, 4), chain, started);
      started = chain;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_idle_ignore();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_mag_comp.md
Name: serial_mag_comp

Overview:
Bit-serial magnitude comparator. It accepts two W-bit operands as a stream of one bit pair per cycle and reports eq/gr/le once the last pair has been consumed. The existing parallel comparator cascades single-bit results from the MSB down; this block runs the same relation sequentially. It sits behind serial links where the parallel operands are never assembled. A start/done handshake frames each comparison.

Parameters:
W, 8, operand width in bits (2..64); number of bit pairs per comparison
MSB_FIRST, 0, stream order: 0 = LSB first, 1 = MSB first

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a new comparison (single-cycle pulse)
bit_valid  input  1  a_bit/b_bit carry a valid pair this cycle
a_bit  input  1  current bit of operand a
b_bit  input  1  current bit of operand b
busy  output  1  comparison in progress (RUN state)
done  output  1  one-cycle pulse: result valid from this cycle
eq  output  1  a == b (registered, held until next start)
gr  output  1  a > b (registered, held until next start)
le  output  1  a < b (registered, held until next start)
cnt  output  $clog2(W+1)  bit pairs consumed in the current comparison

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, done=0, eq=0, gr=0, le=0, cnt=0.
  - Internal relation register rel=EQ.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN next cycle; cnt=0, rel=EQ; eq/gr/le cleared to 0.
  - bit_valid in IDLE is ignored, including a bit_valid in the same cycle as start.
- RUN (busy=1):
  - Each cycle with bit_valid=1 consumes one pair and increments cnt.
  - bit_valid=0 inserts a stall; state and cnt hold.
- Per-pair update, MSB_FIRST=0:
  - a_bit=1, b_bit=0 -> rel=GR.
  - a_bit=0, b_bit=1 -> rel=LE.
  - equal bits -> rel unchanged.
  - Rationale: a later (more significant) differing bit overrides an earlier one.
- Per-pair update, MSB_FIRST=1:
  - rel is updated only while rel==EQ; the first differing bit decides.
  - All remaining pairs are still consumed so cnt reaches W, but they cannot change rel.
- On the cycle the W-th pair is consumed -> DONE next cycle.
- DONE (one cycle):
  - done=1; eq/gr/le loaded from rel, exactly one high; busy=0.
  - Then IDLE. eq/gr/le hold until the next accepted start.
  - Result latency: W valid cycles after the start cycle, +1 cycle.
- start while in RUN: aborts the current comparison and restarts (cnt=0, rel=EQ, eq/gr/le=0). No done is issued for the aborted comparison. Any bit_valid in that same cycle is ignored.
- start while in DONE: done still pulses this cycle with the old result. The new comparison is accepted and the block goes to RUN; eq/gr/le clear on the following cycle.
- bit_valid outside RUN is never consumed; cnt never exceeds W.
- Reset asserted mid-comparison: immediate return to reset values; no done.
- Invariant: eq+gr+le is 0 (no result yet / cleared) or exactly 1 (after done).

Test Plan:
- W=8, MSB_FIRST=0, a=8'hA5, b=8'hA5 streamed LSB first with bit_valid held high after start -> done on cycle 9 after start; eq=1, gr=0, le=0; busy high for cycles 1..8.
- W=8, MSB_FIRST=0, a=8'h81, b=8'h7F -> gr=1 (bit 7 overrides the earlier le decision at bit 1); a=8'h01, b=8'h02 -> le=1.
- W=8, MSB_FIRST=1, a=8'h40, b=8'h3F streamed MSB first -> rel fixed as GR at bit 6; later b-only 1s ignored; gr=1 at done; cnt=8.
- Same vectors with bit_valid low on random cycles (3 stalls) -> identical result; done delayed exactly 3 cycles; cnt holds during stalls.
- start pulsed again after 4 pairs -> no done pulse; cnt returns to 0; the following full 8-pair stream a=8'h10, b=8'h20 -> le=1.
- rst_n pulsed low mid-stream (after 5 pairs) -> all outputs 0 immediately, asynchronously and without a clock edge; a subsequent start plus stream of 8'hFF vs 8'h00 -> gr=1.
